// File: rtl/uart_host_sequencer.sv
// uart_host_sequencer: host-side UART boot-load sequencer.
// Sends size header, program and stdin; captures returned bytes.
module uart_host_sequencer #(
  parameter int         PROG_BYTES   = 96,
  parameter int         STDIN_BYTES  = 128,
  parameter int         RESULT_DEPTH = 128,
  parameter int         SIZE_BYTES   = 4,
  parameter logic [7:0] SYNC_PROG    = 8'h99,
  parameter logic [7:0] SYNC_STDIN   = 8'hAA,
  parameter int         ADDR_W       = 17,
  localparam int RES_AW =
    (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1,
  localparam int CNT_W = $clog2(RESULT_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              src_sel,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_data,
  output logic              res_we,
  output logic [RES_AW-1:0] res_addr,
  output logic [7:0]        res_wdata,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_overflow,
  output logic              done,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_PROG  = 3'd1,
    S_SEND_SIZE  = 3'd2,
    S_SEND_PROG  = 3'd3,
    S_WAIT_STDIN = 3'd4,
    S_SEND_STDIN = 3'd5,
    S_CAPTURE    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    P_LOAD,
    P_ISSUE,
    P_GUARD
  } phase_t;

  localparam logic [31:0] HDR = 32'(PROG_BYTES);
  localparam logic [ADDR_W-1:0] SIZE_LAST =
    ADDR_W'(SIZE_BYTES - 1);
  localparam logic [ADDR_W-1:0] PROG_LAST =
    ADDR_W'(PROG_BYTES - 1);
  localparam logic [ADDR_W-1:0] STDIN_LAST =
    ADDR_W'((STDIN_BYTES > 0) ? STDIN_BYTES - 1 : 0);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RESULT_DEPTH);

  state_t            r_state, w_state_nxt, w_after;
  phase_t            r_ph, w_ph_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic [7:0]        r_tx_data, w_tx_data_nxt;
  logic [CNT_W-1:0]  r_res_count, w_cnt_nxt;
  logic              r_res_ovf, w_ovf_nxt;

  logic       w_send, w_issue, w_last;
  logic       w_cap, w_full;
  logic [7:0] w_hdr, w_byte;

  assign w_send = (r_state == S_SEND_SIZE) ||
                  (r_state == S_SEND_PROG) ||
                  (r_state == S_SEND_STDIN);
  assign w_issue = w_send && (r_ph == P_ISSUE) && !tx_busy;
  assign w_full = (r_res_count == FULL);
  assign w_cap = rx_valid &&
                 ((r_state == S_SEND_STDIN) ||
                  (r_state == S_CAPTURE));

  always_comb begin
    unique case (r_idx[1:0])
      2'd0: w_hdr = HDR[7:0];
      2'd1: w_hdr = HDR[15:8];
      2'd2: w_hdr = HDR[23:16];
      2'd3: w_hdr = HDR[31:24];
    endcase
  end

  // Per-phase byte source, last index and successor state
  always_comb begin
    w_last  = 1'b0;
    w_after = S_IDLE;
    w_byte  = src_data;
    unique case (r_state)
      S_SEND_SIZE: begin
        w_last  = (r_idx == SIZE_LAST);
        w_after = S_SEND_PROG;
        w_byte  = w_hdr;
      end
      S_SEND_PROG: begin
        w_last  = (r_idx == PROG_LAST);
        w_after = S_WAIT_STDIN;
      end
      S_SEND_STDIN: begin
        w_last  = (r_idx == STDIN_LAST);
        w_after = S_CAPTURE;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ph_nxt      = r_ph;
    w_idx_nxt     = r_idx;
    w_tx_data_nxt = r_tx_data;
    w_cnt_nxt     = r_res_count;
    w_ovf_nxt     = r_res_ovf;
    if (w_issue) w_tx_data_nxt = w_byte;
    if (w_cap) begin
      if (w_full) w_ovf_nxt = 1'b1;
      else        w_cnt_nxt = r_res_count + 1'b1;
    end
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_ph_nxt    = P_LOAD;
      w_idx_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_WAIT_PROG;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
          end
        end
        S_WAIT_PROG: begin
          if (rx_valid && rx_data == SYNC_PROG) begin
            w_state_nxt = S_SEND_SIZE;
            w_ph_nxt    = P_LOAD;
            w_idx_nxt   = '0;
          end
        end
        S_WAIT_STDIN: begin
          if (rx_valid && rx_data == SYNC_STDIN) begin
            w_state_nxt = (STDIN_BYTES == 0) ?
                          S_CAPTURE : S_SEND_STDIN;
            w_ph_nxt    = P_LOAD;
            w_idx_nxt   = '0;
          end
        end
        S_SEND_SIZE, S_SEND_PROG, S_SEND_STDIN: begin
          unique case (r_ph)
            P_LOAD:  w_ph_nxt = P_ISSUE;
            P_ISSUE: if (!tx_busy) w_ph_nxt = P_GUARD;
            P_GUARD: begin
              w_ph_nxt = P_LOAD;
              if (w_last) begin
                w_idx_nxt   = '0;
                w_state_nxt = w_after;
              end else begin
                w_idx_nxt = r_idx + 1'b1;
              end
            end
            default: w_ph_nxt = P_LOAD;
          endcase
        end
        S_CAPTURE: ;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_ph        <= P_LOAD;
      r_idx       <= '0;
      r_tx_data   <= '0;
      r_res_count <= '0;
      r_res_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ph        <= w_ph_nxt;
      r_idx       <= w_idx_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_res_count <= w_cnt_nxt;
      r_res_ovf   <= w_ovf_nxt;
    end
  end

  // Issue byte is forwarded straight out, then held in r_tx_data
  assign tx_start = w_issue;
  assign tx_data  = w_issue ? w_byte : r_tx_data;
  assign src_sel  = (r_state == S_SEND_STDIN);
  assign src_addr = ((r_state == S_SEND_PROG) ||
                     (r_state == S_SEND_STDIN)) ? r_idx : '0;

  assign res_we       = w_cap && !w_full;
  assign res_addr     = r_res_count[RES_AW-1:0];
  assign res_wdata    = rx_data;
  assign res_count    = r_res_count;
  assign res_overflow = r_res_ovf;
  assign done         = (r_state == S_CAPTURE);
  assign state        = r_state;

endmodule

// File: tb/tb_uart_host_sequencer.sv
// tb_uart_host_sequencer: randomized self-checking bench.
// Expected TX stream and result buffer come from a queue model.
module tb_uart_host_sequencer;

  localparam int P1 = 4;
  localparam int S1 = 2;
  localparam int Z1 = 4;
  localparam int P2 = 300;
  localparam int Z2 = 2;

  int tests_run = 0;
  int tests_failed = 0;

  logic       clk = 1'b0;
  logic       reset_n, start, abort, rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy = 1'b0;

  logic [7:0]  tx_data1, src_data1, res_wdata1;
  logic        tx_start1, src_sel1, res_we1, res_ovf1, done1;
  logic [16:0] src_addr1;
  logic [1:0]  res_addr1;
  logic [2:0]  res_count1, state1;

  logic [7:0]  tx_data2, src_data2, res_wdata2;
  logic        tx_start2, src_sel2, res_we2, res_ovf2, done2;
  logic [16:0] src_addr2;
  logic [1:0]  res_addr2;
  logic [2:0]  res_count2, state2;

  logic [7:0] prog1 [0:3];
  logic [7:0] stdin1 [0:1];
  logic [7:0] prog2 [0:299];
  logic [7:0] mem1 [0:3];

  logic [7:0] tx_q1[$];
  logic [7:0] tx_q2[$];
  logic [7:0] exp_q[$];
  int         tcyc[$];
  int         cyc = 0;
  int         viol = 0;
  int         wr1 = 0;
  logic       bp_mode = 1'b0;
  int         bp_cnt = 0;

  uart_host_sequencer #(
    .PROG_BYTES(P1), .STDIN_BYTES(S1), .RESULT_DEPTH(4),
    .SIZE_BYTES(Z1)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .tx_data(tx_data1), .tx_start(tx_start1),
    .src_sel(src_sel1), .src_addr(src_addr1),
    .src_data(src_data1), .res_we(res_we1),
    .res_addr(res_addr1), .res_wdata(res_wdata1),
    .res_count(res_count1), .res_overflow(res_ovf1),
    .done(done1), .state(state1)
  );

  uart_host_sequencer #(
    .PROG_BYTES(P2), .STDIN_BYTES(0), .RESULT_DEPTH(4),
    .SIZE_BYTES(Z2)
  ) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .tx_data(tx_data2), .tx_start(tx_start2),
    .src_sel(src_sel2), .src_addr(src_addr2),
    .src_data(src_data2), .res_we(res_we2),
    .res_addr(res_addr2), .res_wdata(res_wdata2),
    .res_count(res_count2), .res_overflow(res_ovf2),
    .done(done2), .state(state2)
  );

  always #5 clk = ~clk;

  // Source memories with one cycle of read latency
  always @(posedge clk) begin
    src_data1 <= src_sel1 ? stdin1[src_addr1[0]]
                          : prog1[src_addr1[1:0]];
    src_data2 <= prog2[src_addr2[8:0]];
  end

  always @(negedge clk) begin
    cyc++;
    if (tx_start1) begin
      tx_q1.push_back(tx_data1);
      tcyc.push_back(cyc);
      if (tx_busy) viol++;
    end
    if (tx_start2) tx_q2.push_back(tx_data2);
    if (res_we1) begin
      mem1[res_addr1] = res_wdata1;
      wr1++;
    end
  end

  // Busy generator: high for 50 cycles after each tx_start
  always @(posedge clk) begin
    #1;
    if (!bp_mode) begin
      tx_busy = 1'b0;
      bp_cnt = 0;
    end else if (tcyc.size() > 0 && tcyc[$] == cyc) begin
      tx_busy = 1'b1;
      bp_cnt = 50;
    end else if (bp_cnt > 0) begin
      bp_cnt--;
      if (bp_cnt == 0) tx_busy = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: sim did not finish, required $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < P1; i++) prog1[i] = 8'($urandom);
    for (int i = 0; i < S1; i++) stdin1[i] = 8'($urandom);
    for (int i = 0; i < P2; i++) prog2[i] = 8'($urandom);
  endtask

  // Reference stream: LE size header, program, stdin
  task automatic build_exp(input int which);
    exp_q.delete();
    if (which == 1) begin
      for (int k = 0; k < Z1; k++)
        exp_q.push_back(8'((P1 >> (8 * k)) & 255));
      for (int i = 0; i < P1; i++) exp_q.push_back(prog1[i]);
      for (int i = 0; i < S1; i++) exp_q.push_back(stdin1[i]);
    end else begin
      for (int k = 0; k < Z2; k++)
        exp_q.push_back(8'((P2 >> (8 * k)) & 255));
      for (int i = 0; i < P2; i++) exp_q.push_back(prog2[i]);
    end
  endtask

  task automatic goto_capture(input int bound);
    int n;
    pulse_abort();
    pulse_start();
    rx_byte(8'h99);
    n = 0;
    while (state1 !== 3'd4 && n < bound) begin tick(); n++; end
    tests_run++;
    if (state1 !== 3'd4) begin
      tests_failed++;
      $display("FAIL reach_wait_stdin: state %0d, required 4", state1);
    end
    rx_byte(8'hAA);
    n = 0;
    while (state1 !== 3'd6 && n < bound) begin tick(); n++; end
    tests_run++;
    if (state1 !== 3'd6) begin
      tests_failed++;
      $display("FAIL reach_capture: state %0d, required 6", state1);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00;
    #2;
    tests_run += 10;
    if (state1 !== 3'd0) begin tests_failed++; $display("FAIL rst_state: got %0d, required 0", state1); end
    if (tx_start1 !== 1'b0) begin tests_failed++; $display("FAIL rst_tx_start: got %b, required 0", tx_start1); end
    if (tx_data1 !== 8'h00) begin tests_failed++; $display("FAIL rst_tx_data: got %h, required 00", tx_data1); end
    if (src_sel1 !== 1'b0) begin tests_failed++; $display("FAIL rst_src_sel: got %b, required 0", src_sel1); end
    if (src_addr1 !== 17'd0) begin tests_failed++; $display("FAIL rst_src_addr: got %h, required 0", src_addr1); end
    if (res_we1 !== 1'b0) begin tests_failed++; $display("FAIL rst_res_we: got %b, required 0", res_we1); end
    if (res_count1 !== 3'd0) begin tests_failed++; $display("FAIL rst_res_count: got %0d, required 0", res_count1); end
    if (res_ovf1 !== 1'b0) begin tests_failed++; $display("FAIL rst_ovf: got %b, required 0", res_ovf1); end
    if (done1 !== 1'b0) begin tests_failed++; $display("FAIL rst_done: got %b, required 0", done1); end
    if (state2 !== 3'd0) begin tests_failed++; $display("FAIL rst_state2: got %0d, required 0", state2); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    @(negedge clk);
    tests_run++;
    if (state1 !== 3'd0) begin tests_failed++; $display("FAIL idle_after_reset: got %0d, required 0", state1); end
  endtask

  task automatic test_full_flow();
    int qb, tb0, got, n;
    prog1[0] = 8'h11; prog1[1] = 8'h22;
    prog1[2] = 8'h33; prog1[3] = 8'h44;
    stdin1[0] = 8'h55; stdin1[1] = 8'h66;
    build_exp(1);
    qb = tx_q1.size();
    tb0 = tcyc.size();
    pulse_abort();
    pulse_start();
    @(negedge clk);
    tests_run++;
    if (state1 !== 3'd1) begin tests_failed++; $display("FAIL start_state: got %0d, required 1", state1); end
    tick();
    rx_byte(8'h99);
    @(negedge clk);
    tests_run += 2;
    if (state1 !== 3'd2) begin tests_failed++; $display("FAIL sync_state: got %0d, required 2", state1); end
    if (tx_start1 !== 1'b0) begin tests_failed++; $display("FAIL load_no_start: got %b, required 0", tx_start1); end
    tick();
    @(negedge clk);
    tests_run += 2;
    if (tx_start1 !== 1'b1) begin tests_failed++; $display("FAIL first_start: got %b, required 1", tx_start1); end
    if (tx_data1 !== 8'h04) begin tests_failed++; $display("FAIL first_byte: got %h, required 04", tx_data1); end
    n = 0;
    while (state1 !== 3'd4 && n < 200) begin tick(); n++; end
    rx_byte(8'hAA);
    n = 0;
    while (state1 !== 3'd6 && n < 200) begin tick(); n++; end
    @(negedge clk);
    tests_run += 3;
    if (done1 !== 1'b1) begin tests_failed++; $display("FAIL flow_done: got %b, required 1", done1); end
    if (res_count1 !== 3'd0) begin tests_failed++; $display("FAIL flow_count: got %0d, required 0", res_count1); end
    got = tx_q1.size() - qb;
    if (got != exp_q.size()) begin tests_failed++; $display("FAIL flow_len: got %0d, required %0d", got, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got; i++) begin
      tests_run++;
      if (tx_q1[qb + i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL flow_byte[%0d]: got %h, required %h", i, tx_q1[qb + i], exp_q[i]);
      end
    end
    for (int i = 1; i < 10 && tb0 + i < tcyc.size(); i++) begin
      if (i == 8) continue;
      tests_run++;
      if (tcyc[tb0 + i] - tcyc[tb0 + i - 1] != 3) begin
        tests_failed++;
        $display("FAIL cadence[%0d]: got %0d cycles, required 3", i, tcyc[tb0 + i] - tcyc[tb0 + i - 1]);
      end
    end
  endtask

  task automatic test_sync_filter();
    logic [7:0] b;
    int wb;
    wb = wr1;
    pulse_abort();
    pulse_start();
    rx_byte(8'h98);
    rx_byte(8'hAA);
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      if (b == 8'h99) b = 8'h98;
      rx_byte(b);
    end
    @(negedge clk);
    tests_run += 3;
    if (state1 !== 3'd1) begin tests_failed++; $display("FAIL filter_state: got %0d, required 1", state1); end
    if (res_count1 !== 3'd0) begin tests_failed++; $display("FAIL filter_count: got %0d, required 0", res_count1); end
    if (wr1 != wb) begin tests_failed++; $display("FAIL filter_writes: got %0d, required 0", wr1 - wb); end
    tick();
    rx_byte(8'h99);
    @(negedge clk);
    tests_run++;
    if (state1 !== 3'd2) begin tests_failed++; $display("FAIL filter_advance: got %0d, required 2", state1); end
    tick();
  endtask

  task automatic test_capture_stdin();
    logic [7:0] rb [0:2];
    int n, qb;
    randomize_data();
    build_exp(1);
    pulse_abort();
    pulse_start();
    rx_byte(8'h99);
    n = 0;
    while (state1 !== 3'd4 && n < 200) begin tick(); n++; end
    qb = tx_q1.size();
    rx_byte(8'hAA);
    for (int i = 0; i < 3; i++) rb[i] = 8'($urandom);
    rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin rx_data = rb[i]; tick(); end
    rx_valid = 1'b0;
    n = 0;
    while (state1 !== 3'd6 && n < 200) begin tick(); n++; end
    @(negedge clk);
    tests_run += 4;
    if (res_count1 !== 3'd3) begin tests_failed++; $display("FAIL cap_count: got %0d, required 3", res_count1); end
    if (res_ovf1 !== 1'b0) begin tests_failed++; $display("FAIL cap_ovf: got %b, required 0", res_ovf1); end
    if (tx_q1.size() - qb != S1) begin tests_failed++; $display("FAIL cap_stdin_len: got %0d, required %0d", tx_q1.size() - qb, S1); end
    if (state1 !== 3'd6) begin tests_failed++; $display("FAIL cap_state: got %0d, required 6", state1); end
    for (int i = 0; i < S1 && qb + i < tx_q1.size(); i++) begin
      tests_run++;
      if (tx_q1[qb + i] !== stdin1[i]) begin tests_failed++; $display("FAIL cap_stdin[%0d]: got %h, required %h", i, tx_q1[qb + i], stdin1[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (mem1[i] !== rb[i]) begin tests_failed++; $display("FAIL cap_mem[%0d]: got %h, required %h", i, mem1[i], rb[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] rb [0:5];
    int wb;
    randomize_data();
    goto_capture(200);
    wb = wr1;
    for (int i = 0; i < 6; i++) begin
      rb[i] = (i < 2) ? 8'(i + 1) : 8'($urandom);
      rx_byte(rb[i]);
      repeat ($urandom_range(0, 2)) tick();
    end
    @(negedge clk);
    tests_run += 3;
    if (res_count1 !== 3'd4) begin tests_failed++; $display("FAIL ovf_count: got %0d, required 4", res_count1); end
    if (res_ovf1 !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b, required 1", res_ovf1); end
    if (wr1 - wb != 4) begin tests_failed++; $display("FAIL ovf_writes: got %0d, required 4", wr1 - wb); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (mem1[i] !== rb[i]) begin tests_failed++; $display("FAIL ovf_mem[%0d]: got %h, required %h", i, mem1[i], rb[i]); end
    end
    tick();
    pulse_abort();
    @(negedge clk);
    tests_run += 3;
    if (state1 !== 3'd0) begin tests_failed++; $display("FAIL ovf_abort_state: got %0d, required 0", state1); end
    if (res_count1 !== 3'd4) begin tests_failed++; $display("FAIL abort_keeps_count: got %0d, required 4", res_count1); end
    if (res_ovf1 !== 1'b1) begin tests_failed++; $display("FAIL abort_keeps_ovf: got %b, required 1", res_ovf1); end
    tick();
    pulse_start();
    @(negedge clk);
    tests_run += 2;
    if (res_count1 !== 3'd0) begin tests_failed++; $display("FAIL start_clears_count: got %0d, required 0", res_count1); end
    if (res_ovf1 !== 1'b0) begin tests_failed++; $display("FAIL start_clears_ovf: got %b, required 0", res_ovf1); end
    tick();
  endtask

  task automatic test_back_pressure();
    int qb, vb, got;
    randomize_data();
    build_exp(1);
    qb = tx_q1.size();
    vb = viol;
    bp_mode = 1'b1;
    goto_capture(2000);
    bp_mode = 1'b0;
    tick();
    got = tx_q1.size() - qb;
    tests_run += 2;
    if (got != 10) begin tests_failed++; $display("FAIL bp_count: got %0d, required 10", got); end
    if (viol != vb) begin tests_failed++; $display("FAIL bp_start_while_busy: got %0d, required 0", viol - vb); end
    for (int i = 0; i < exp_q.size() && i < got; i++) begin
      tests_run++;
      if (tx_q1[qb + i] !== exp_q[i]) begin tests_failed++; $display("FAIL bp_byte[%0d]: got %h, required %h", i, tx_q1[qb + i], exp_q[i]); end
    end
  endtask

  task automatic test_stdin_zero();
    int qb, n, got;
    randomize_data();
    build_exp(2);
    pulse_abort();
    qb = tx_q2.size();
    pulse_start();
    rx_byte(8'h99);
    n = 0;
    while (state2 !== 3'd4 && n < 2000) begin tick(); n++; end
    got = tx_q2.size() - qb;
    tests_run += 3;
    if (state2 !== 3'd4) begin tests_failed++; $display("FAIL z_wait_stdin: got %0d, required 4", state2); end
    if (got != exp_q.size()) begin tests_failed++; $display("FAIL z_len: got %0d, required %0d", got, exp_q.size()); end
    if (got >= 2 && (tx_q2[qb] !== 8'h2C || tx_q2[qb + 1] !== 8'h01)) begin
      tests_failed++;
      $display("FAIL z_header: got %h %h, required 2c 01", tx_q2[qb], tx_q2[qb + 1]);
    end
    for (int i = 0; i < exp_q.size() && i < got; i++) begin
      if (tx_q2[qb + i] !== exp_q[i]) begin
        tests_run++;
        tests_failed++;
        $display("FAIL z_byte[%0d]: got %h, required %h", i, tx_q2[qb + i], exp_q[i]);
      end
    end
    rx_byte(8'hAA);
    @(negedge clk);
    tests_run += 2;
    if (state2 !== 3'd6) begin tests_failed++; $display("FAIL z_capture: got %0d, required 6", state2); end
    if (done2 !== 1'b1) begin tests_failed++; $display("FAIL z_done: got %b, required 1", done2); end
    repeat (10) tick();
    tests_run++;
    if (tx_q2.size() - qb != exp_q.size()) begin tests_failed++; $display("FAIL z_no_stdin_tx: got %0d, required %0d", tx_q2.size() - qb, exp_q.size()); end
  endtask

  task automatic test_abort();
    int qb, n;
    randomize_data();
    pulse_abort();
    qb = tx_q1.size();
    pulse_start();
    rx_byte(8'h99);
    n = 0;
    while (tx_q1.size() - qb < 6 && n < 100) begin tick(); n++; end
    abort = 1'b1;
    @(negedge clk);
    tests_run++;
    if (state1 !== 3'd3) begin tests_failed++; $display("FAIL abort_pre_state: got %0d, required 3", state1); end
    tick();
    abort = 1'b0;
    @(negedge clk);
    tests_run++;
    if (state1 !== 3'd0) begin tests_failed++; $display("FAIL abort_state: got %0d, required 0", state1); end
    repeat (30) tick();
    tests_run++;
    if (tx_q1.size() - qb != 6) begin tests_failed++; $display("FAIL abort_no_tx: got %0d starts, required 6", tx_q1.size() - qb); end
  endtask

  task automatic test_reset_mid();
    int qb, n;
    randomize_data();
    pulse_abort();
    pulse_start();
    rx_byte(8'h99);
    n = 0;
    while (state1 !== 3'd4 && n < 200) begin tick(); n++; end
    rx_byte(8'hAA);
    rx_byte(8'($urandom));
    tests_run++;
    if (res_count1 !== 3'd1) begin tests_failed++; $display("FAIL mid_count: got %0d, required 1", res_count1); end
    #2 reset_n = 1'b0;
    #1;
    tests_run += 9;
    if (state1 !== 3'd0) begin tests_failed++; $display("FAIL mrst_state: got %0d, required 0", state1); end
    if (tx_start1 !== 1'b0) begin tests_failed++; $display("FAIL mrst_tx_start: got %b, required 0", tx_start1); end
    if (tx_data1 !== 8'h00) begin tests_failed++; $display("FAIL mrst_tx_data: got %h, required 00", tx_data1); end
    if (src_sel1 !== 1'b0) begin tests_failed++; $display("FAIL mrst_src_sel: got %b, required 0", src_sel1); end
    if (src_addr1 !== 17'd0) begin tests_failed++; $display("FAIL mrst_src_addr: got %h, required 0", src_addr1); end
    if (res_we1 !== 1'b0) begin tests_failed++; $display("FAIL mrst_res_we: got %b, required 0", res_we1); end
    if (res_count1 !== 3'd0) begin tests_failed++; $display("FAIL mrst_count: got %0d, required 0", res_count1); end
    if (res_ovf1 !== 1'b0) begin tests_failed++; $display("FAIL mrst_ovf: got %b, required 0", res_ovf1); end
    if (done1 !== 1'b0) begin tests_failed++; $display("FAIL mrst_done: got %b, required 0", done1); end
    #3 reset_n = 1'b1;
    qb = tx_q1.size();
    repeat (5) tick();
    tests_run += 2;
    if (state1 !== 3'd0) begin tests_failed++; $display("FAIL mrst_resume: got %0d, required 0", state1); end
    if (tx_q1.size() != qb) begin tests_failed++; $display("FAIL mrst_no_tx: got %0d starts, required 0", tx_q1.size() - qb); end
  endtask

  initial begin
    test_reset();
    test_full_flow();
    test_sync_filter();
    test_capture_stdin();
    test_overflow();
    test_back_pressure();
    test_stdin_zero();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_host_sequencer.md
# uart_host_sequencer

Synthesizable, parametrised host-side UART load sequencer. It runs the program/stdin download handshake against the CPU's boot loader: wait for a program sync byte, send a little-endian program-size header, stream the program image, wait for a stdin sync byte, stream stdin, and capture every byte returned by the CPU into a result buffer. It sits between a byte-source memory and the `UART_TX`/`UART_RX` pair. It replaces the behavioural bench server and can be instantiated on an FPGA host board.

## Interface
- `PROG_BYTES`, 96: program image length in bytes; also the value sent in the size header.
- `STDIN_BYTES`, 128: stdin length in bytes; 0 is legal.
- `RESULT_DEPTH`, 128: result buffer depth in bytes.
- `SIZE_BYTES`, 4: size header length in bytes, 1..4.
- `SYNC_PROG`, 8'h99: byte that opens the program phase.
- `SYNC_STDIN`, 8'hAA: byte that opens the stdin phase.
- `ADDR_W`, 17: source address width.
- `clk` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin; honoured only in IDLE.
- `abort` in 1: synchronous; forces IDLE from any state next cycle; result count and overflow flag are kept.
- `rx_data` in 8: received byte from `UART_RX`.
- `rx_valid` in 1: one-cycle strobe qualifying `rx_data`.
- `tx_busy` in 1: `UART_TX` busy.
- `tx_data` out 8: byte to transmit; held stable from `tx_start` until the next load.
- `tx_start` out 1: one-cycle transmit pulse.
- `src_sel` out 1: source region select; 0 = program, 1 = stdin.
- `src_addr` out ADDR_W: byte index into the selected region.
- `src_data` in 8: source byte; valid one cycle after `src_addr`/`src_sel` change.
- `res_we` out 1: result write strobe.
- `res_addr` out clog2(RESULT_DEPTH): result write address.
- `res_wdata` out 8: result write data.
- `res_count` out clog2(RESULT_DEPTH+1): bytes stored so far.
- `res_overflow` out 1: sticky; set when a byte is dropped because the buffer is full.
- `done` out 1: high while in CAPTURE.
- `state` out 3: current state encoding.

## Operation
- States and encodings:
  - IDLE = 0
  - WAIT_PROG = 1
  - SEND_SIZE = 2
  - SEND_PROG = 3
  - WAIT_STDIN = 4
  - SEND_STDIN = 5
  - CAPTURE = 6
- IDLE -> WAIT_PROG on `start`. Starting clears `res_count` and `res_overflow`.
- WAIT_PROG -> SEND_SIZE on `rx_valid && rx_data==SYNC_PROG`. Any other received byte is ignored.
- SEND_SIZE: sends `PROG_BYTES` as `SIZE_BYTES` bytes, least-significant byte first, byte k = `PROG_BYTES[8k+7:8k]`. After the last byte -> SEND_PROG.
- SEND_PROG: sends `src_data` for `src_addr` = 0..PROG_BYTES-1 with `src_sel`=0, then -> WAIT_STDIN.
- WAIT_STDIN -> SEND_STDIN on `rx_valid && rx_data==SYNC_STDIN`. Other bytes are ignored.
- SEND_STDIN: sends addresses 0..STDIN_BYTES-1 with `src_sel`=1, then -> CAPTURE. If `STDIN_BYTES`==0, go straight to CAPTURE.
- CAPTURE: terminal state. Leaves only on `abort` or reset.
- Capture rule: in SEND_STDIN and CAPTURE only, each `rx_valid` causes `res_we`=1, `res_addr`=`res_count`, `res_wdata`=`rx_data` in the same cycle, and `res_count` increments at the next edge.
- Buffer full: when `res_count`==`RESULT_DEPTH`, the byte is dropped, `res_we` stays 0 and `res_overflow` is set. The count never wraps.
- `rx_valid` in WAIT states never writes the result buffer, even when the byte does not match.

## Timing
- Reset values:
  - `tx_start`=0, `tx_data`=0
  - `src_sel`=0, `src_addr`=0
  - `res_we`=0, `res_count`=0, `res_overflow`=0
  - `done`=0, `state`=IDLE
- Per-byte send cadence:
  - LOAD cycle: address or header byte is selected.
  - ISSUE: earliest following cycle with `tx_busy`=0. `tx_data` is loaded and `tx_start`=1 for exactly one cycle.
  - GUARD: one cycle in which `tx_busy` is ignored.
  - Then LOAD of the next byte.
  - With `tx_busy` held 0, one `tx_start` every 3 cycles.
- First SEND_SIZE LOAD is the cycle after the sync match, so the first `tx_start` is 2 cycles after the sync `rx_valid` cycle.
- The phase transition after the last byte occurs in the GUARD cycle.
- `abort` or reset during a send: `tx_start` is never reasserted. A byte already started in `UART_TX` completes; this is out of scope for this block.
- `abort` and `start` in the same cycle: `abort` wins.
- `rx_valid` coinciding with `tx_start`: both are serviced; capture is independent of the send cadence.
- Async reset deasserting mid-frame: the block resumes in IDLE.

## Test plan
Unless stated otherwise: `PROG_BYTES`=4, `STDIN_BYTES`=2, `SIZE_BYTES`=4, `RESULT_DEPTH`=4, `tx_busy`=0, program = 11 22 33 44, stdin = 55 66.

- Full flow: `start`, rx 0x99, rx 0xAA -> TX sequence 04 00 00 00 11 22 33 44, then 55 66; `done`=1.
- Sync filtering: in WAIT_PROG, rx 0x98, 0xAA, 0x99 -> only 0x99 advances the state; `res_count` stays 0.
- Overflow: in CAPTURE, rx 6 bytes 01..06 -> buffer holds 01..04; `res_count`=4; `res_overflow`=1.
- Busy back-pressure: `tx_busy`=1 for 50 cycles after each `tx_start` -> exactly 10 `tx_start` pulses; none while busy; byte order unchanged.
- `STDIN_BYTES`=0 with `SIZE_BYTES`=2, `PROG_BYTES`=300 -> header 2C 01; after 0xAA, state goes to CAPTURE with no stdin `tx_start`.
- Reset/abort: `abort` during SEND_PROG after 2 bytes -> IDLE next cycle and no further `tx_start`. `reset_n` low mid-stream -> all outputs at reset values immediately.
